// File: rtl/csr_unit_if.sv
// CSR port bundle between the pipeline (master) and the CSR responder (slave).
interface csr_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic            instr_valid;
   logic            csr_reg_r;
   logic            csr_reg_wr;
   logic            is_mret;
   logic [11:0]     csr_addr;
   logic [XLEN-1:0] csr_wdata;
   logic [XLEN-1:0] pc_next;
   logic [XLEN-1:0] csr_rdata;
   logic            epc_taken;
   logic [XLEN-1:0] epc;

   modport master (
      output instr_valid, csr_reg_r, csr_reg_wr, is_mret, csr_addr, csr_wdata, pc_next,
      input  csr_rdata, epc_taken, epc
   );

   modport slave (
      input  instr_valid, csr_reg_r, csr_reg_wr, is_mret, csr_addr, csr_wdata, pc_next,
      output csr_rdata, epc_taken, epc
   );
endinterface

// File: rtl/csr_unit.sv
// Machine-mode CSR file with timer/external interrupt entry and MRET redirect.
module csr_unit #(
   parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
   parameter int unsigned XLEN        = 32
) (
   input  logic      clk_i,
   input  logic      rst_i,        // synchronous, active low
   input  logic      timer_irq_i,
   input  logic      ext_irq_i,
   csr_unit_if.slave bus
);

   localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
   localparam logic [11:0] ADDR_MIE      = 12'h304;
   localparam logic [11:0] ADDR_MTVEC    = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
   localparam logic [11:0] ADDR_MEPC     = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
   localparam logic [11:0] ADDR_MIP      = 12'h344;

   localparam logic [4:0] CAUSE_TIMER = 5'd7;
   localparam logic [4:0] CAUSE_EXT   = 5'd11;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_TRAP = 2'd1,
      ST_RET  = 2'd2
   } state_e;

   state_e          state_q;
   logic            mstat_mie_q;
   logic            mstat_mpie_q;
   logic            mtie_q;
   logic            meie_q;
   logic            mtip_q;
   logic            meip_q;
   logic [XLEN-1:0] mtvec_q;
   logic [XLEN-1:0] mscratch_q;
   logic [XLEN-1:0] mepc_q;
   logic [XLEN-1:0] mcause_q;
   logic            epc_taken_q;
   logic [XLEN-1:0] epc_q;

   logic            accept_c;
   logic            irq_go_c;
   logic [4:0]      irq_cause_c;
   logic [XLEN-1:0] vec_addr_c;
   logic [XLEN-1:0] rdata_c;

   // Interrupt decision uses the pre-write CSR state; mret suppresses it.
   always_comb begin
      accept_c    = (state_q == ST_RUN) && bus.instr_valid;
      irq_go_c    = accept_c && mstat_mie_q && ((mtie_q && mtip_q) || (meie_q && meip_q))
                    && !bus.is_mret;
      irq_cause_c = (meie_q && meip_q) ? CAUSE_EXT : CAUSE_TIMER;
      vec_addr_c  = {mtvec_q[XLEN-1:2], 2'b00};
      if (mtvec_q[1:0] == 2'b01) begin
         vec_addr_c = vec_addr_c + (XLEN'(irq_cause_c) << 2);
      end
   end

   // Old-value read mux, zero for unmapped addresses.
   always_comb begin
      rdata_c = '0;
      if (bus.csr_reg_r) begin
         case (bus.csr_addr)
            ADDR_MSTATUS:  rdata_c = XLEN'({mstat_mpie_q, 3'b000, mstat_mie_q, 3'b000});
            ADDR_MIE:      rdata_c = XLEN'({meie_q, 3'b000, mtie_q, 7'b0000000});
            ADDR_MTVEC:    rdata_c = mtvec_q;
            ADDR_MSCRATCH: rdata_c = mscratch_q;
            ADDR_MEPC:     rdata_c = mepc_q;
            ADDR_MCAUSE:   rdata_c = mcause_q;
            ADDR_MIP:      rdata_c = XLEN'({meip_q, 3'b000, mtip_q, 7'b0000000});
            default:       rdata_c = '0;
         endcase
      end
   end

   // CSR state, interrupt sampling and the RUN/TRAP/RET sequencer; trap/mret
   // updates are placed after the CSR write so they take priority.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q      <= ST_RUN;
         mstat_mie_q  <= 1'b0;
         mstat_mpie_q <= 1'b0;
         mtie_q       <= 1'b0;
         meie_q       <= 1'b0;
         mtip_q       <= 1'b0;
         meip_q       <= 1'b0;
         mtvec_q      <= XLEN'(RESET_MTVEC);
         mscratch_q   <= '0;
         mepc_q       <= '0;
         mcause_q     <= '0;
         epc_taken_q  <= 1'b0;
         epc_q        <= '0;
      end else begin
         mtip_q      <= timer_irq_i;
         meip_q      <= ext_irq_i;
         epc_taken_q <= 1'b0;
         state_q     <= ST_RUN;

         if (accept_c) begin
            if (bus.csr_reg_wr) begin
               case (bus.csr_addr)
                  ADDR_MSTATUS: begin
                     mstat_mie_q  <= bus.csr_wdata[3];
                     mstat_mpie_q <= bus.csr_wdata[7];
                  end
                  ADDR_MIE: begin
                     mtie_q <= bus.csr_wdata[7];
                     meie_q <= bus.csr_wdata[11];
                  end
                  ADDR_MTVEC:    mtvec_q    <= bus.csr_wdata & ~XLEN'(2);
                  ADDR_MSCRATCH: mscratch_q <= bus.csr_wdata;
                  ADDR_MEPC:     mepc_q     <= {bus.csr_wdata[XLEN-1:2], 2'b00};
                  ADDR_MCAUSE:   mcause_q   <= bus.csr_wdata;
                  default: ;
               endcase
            end

            if (bus.is_mret) begin
               mstat_mie_q  <= mstat_mpie_q;
               mstat_mpie_q <= 1'b1;
               epc_q        <= mepc_q;
               epc_taken_q  <= 1'b1;
               state_q      <= ST_RET;
            end else if (irq_go_c) begin
               mepc_q       <= bus.pc_next;
               mcause_q     <= {1'b1, (XLEN-1)'(irq_cause_c)};
               mstat_mpie_q <= mstat_mie_q;
               mstat_mie_q  <= 1'b0;
               epc_q        <= vec_addr_c;
               epc_taken_q  <= 1'b1;
               state_q      <= ST_TRAP;
            end
         end
      end
   end

   assign bus.csr_rdata = rdata_c;
   assign bus.epc_taken = epc_taken_q;
   assign bus.epc       = epc_q;

endmodule

// File: tb/tb_csr_unit.sv
// Scoreboard bench for csr_unit: stimulus queues expected read data and
// redirect targets, a negedge monitor pops and compares them.
module tb_csr_unit;

   localparam logic [31:0] RST_VEC = 32'h0000_1000;

   typedef struct {
      string       name;
      logic [31:0] val;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic timer_irq;
   logic ext_irq;

   int n_chk  = 0;
   int n_fail = 0;

   exp_t rd_q[$];
   exp_t epc_q[$];
   logic prev_taken = 1'b0;

   csr_unit_if bus_if ();

   csr_unit #(.RESET_MTVEC(RST_VEC), .XLEN(32)) dut (
      .clk_i       (clk),
      .rst_i       (rst_n),
      .timer_irq_i (timer_irq),
      .ext_irq_i   (ext_irq),
      .bus         (bus_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Monitor: compares presented read data and redirects against the queues.
   always @(negedge clk) begin
      exp_t e;
      if (bus_if.csr_reg_r) begin
         if (rd_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_read: got %h, required no read", bus_if.csr_rdata);
         end else begin
            e = rd_q.pop_front();
            chk(e.name, bus_if.csr_rdata, e.val);
         end
      end
      if (bus_if.epc_taken) begin
         if (prev_taken) begin
            n_chk++; n_fail++;
            $display("FAIL epc_pulse_width: got epc_taken held 2 cycles, required 1");
         end
         if (epc_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_redirect: got epc %h, required no redirect", bus_if.epc);
         end else begin
            e = epc_q.pop_front();
            chk(e.name, bus_if.epc, e.val);
         end
      end
      prev_taken = bus_if.epc_taken;
   end

   // One pipeline slot: drive strobes, cross one edge, return strobes to idle.
   task automatic op(input logic v, input logic r, input logic w, input logic m,
                     input logic [11:0] a, input logic [31:0] wd, input logic [31:0] pc);
      bus_if.instr_valid = v;
      bus_if.csr_reg_r   = r;
      bus_if.csr_reg_wr  = w;
      bus_if.is_mret     = m;
      bus_if.csr_addr    = a;
      bus_if.csr_wdata   = wd;
      bus_if.pc_next     = pc;
      @(posedge clk); #1;
      bus_if.instr_valid = 1'b0;
      bus_if.csr_reg_r   = 1'b0;
      bus_if.csr_reg_wr  = 1'b0;
      bus_if.is_mret     = 1'b0;
   endtask

   task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
      rd_q.push_back('{name, exp});
      op(1'b0, 1'b1, 1'b0, 1'b0, a, 32'h0, 32'h0);
   endtask

   task automatic rw(input string name, input logic [11:0] a, input logic [31:0] wd,
                     input logic [31:0] old, input logic [31:0] pc);
      rd_q.push_back('{name, old});
      op(1'b1, 1'b1, 1'b1, 1'b0, a, wd, pc);
   endtask

   task automatic instr(input logic [31:0] pc);
      op(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, pc);
   endtask

   task automatic mret(input logic [31:0] pc);
      op(1'b1, 1'b0, 1'b0, 1'b1, 12'h000, 32'h0, pc);
   endtask

   task automatic expect_redirect(input string name, input logic [31:0] target);
      epc_q.push_back('{name, target});
   endtask

   task automatic read_reset_values(input string tag);
      rd({tag, "_mstatus"},  12'h300, 32'h0);
      rd({tag, "_mie"},      12'h304, 32'h0);
      rd({tag, "_mtvec"},    12'h305, RST_VEC);
      rd({tag, "_mscratch"}, 12'h340, 32'h0);
      rd({tag, "_mepc"},     12'h341, 32'h0);
      rd({tag, "_mcause"},   12'h342, 32'h0);
      rd({tag, "_mip"},      12'h344, 32'h0);
   endtask

   // Watchdog bound on the whole run.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1);
   end

   // Directed stimulus.
   initial begin
      bus_if.instr_valid = 1'b0;
      bus_if.csr_reg_r   = 1'b0;
      bus_if.csr_reg_wr  = 1'b0;
      bus_if.is_mret     = 1'b0;
      bus_if.csr_addr    = 12'h0;
      bus_if.csr_wdata   = 32'h0;
      bus_if.pc_next     = 32'h0;
      timer_irq = 1'b0;
      ext_irq   = 1'b0;
      rst_n     = 1'b0;

      // Reset for two cycles
      repeat (2) @(posedge clk);
      #1;
      chk("reset_epc_taken", {31'h0, bus_if.epc_taken}, 32'h0);
      rst_n = 1'b1;
      read_reset_values("rst");
      rd("unmapped", 12'h123, 32'h0);

      // mscratch round trip and write masks
      rw("mscratch_first",  12'h340, 32'hDEAD_BEEF, 32'h0, 32'h4);
      rw("mscratch_second", 12'h340, 32'h0, 32'hDEAD_BEEF, 32'h8);
      rd("mscratch_zero",   12'h340, 32'h0);
      rw("mepc_wr",         12'h341, 32'h0000_1237, 32'h0, 32'hC);
      rd("mepc_masked",     12'h341, 32'h0000_1234);
      rw("mip_wr",          12'h344, 32'hFFFF_FFFF, 32'h0, 32'h10);
      rd("mip_readonly",    12'h344, 32'h0);
      rw("mstatus_all",     12'h300, 32'hFFFF_FFFF, 32'h0, 32'h14);
      rw("mstatus_masked",  12'h300, 32'h0, 32'h88, 32'h18);

      // Direct-mode timer trap
      rw("mtvec_rst_old",   12'h305, 32'h100, RST_VEC, 32'h1C);
      rw("mie_old",         12'h304, 32'h80, 32'h0, 32'h20);
      rw("mstatus_old",     12'h300, 32'h8, 32'h0, 32'h24);
      timer_irq = 1'b1;
      op(1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0);
      rd("mip_timer",       12'h344, 32'h80);
      expect_redirect("epc_direct", 32'h100);
      instr(32'h40);
      rw("trap_cycle_wr_ignored", 12'h340, 32'h5555_5555, 32'h0, 32'h44);
      rd("mscratch_unchanged", 12'h340, 32'h0);
      rd("mepc_direct",     12'h341, 32'h40);
      rd("mcause_timer",    12'h342, 32'h8000_0007);
      rd("mstatus_trap",    12'h300, 32'h80);

      // MRET then re-taken timer trap
      expect_redirect("epc_mret", 32'h40);
      mret(32'h104);
      rd("mstatus_ret",     12'h300, 32'h88);
      expect_redirect("epc_retrap", 32'h100);
      instr(32'h48);
      rd("mepc_retrap",     12'h341, 32'h48);
      rd("mstatus_retrap",  12'h300, 32'h80);

      // Vectored external trap (external beats timer)
      rw("mtvec_old",       12'h305, 32'h103, 32'h100, 32'h104);
      rd("mtvec_bit1",      12'h305, 32'h101);
      ext_irq = 1'b1;
      rw("mie_old2",        12'h304, 32'h880, 32'h80, 32'h108);
      rw("mstatus_prewr",   12'h300, 32'h8, 32'h80, 32'h10C);
      expect_redirect("epc_vectored", 32'h12C);
      instr(32'h60);
      rd("mcause_ext",      12'h342, 32'h8000_000B);
      rd("mepc_vectored",   12'h341, 32'h60);

      // Trap value of mepc beats a same-cycle mepc write
      expect_redirect("epc_mret2", 32'h60);
      mret(32'h130);
      rd("mstatus_ret2",    12'h300, 32'h88);
      expect_redirect("epc_mepc_race", 32'h12C);
      rw("mepc_race_old",   12'h341, 32'h0000_ABC0, 32'h60, 32'h70);
      rd("mepc_trap_wins",  12'h341, 32'h70);

      // mret and a pending interrupt together: mret wins
      rw("mstatus_pre_mret", 12'h300, 32'h8, 32'h80, 32'h130);
      expect_redirect("epc_mret_vs_irq", 32'h70);
      mret(32'h134);
      rd("mcause_kept",     12'h342, 32'h8000_000B);
      rd("mstatus_mret_irq", 12'h300, 32'h80);

      // Reset during the TRAP cycle
      rw("mstatus_pre_rst", 12'h300, 32'h8, 32'h80, 32'h138);
      expect_redirect("epc_before_rst", 32'h12C);
      instr(32'h90);
      rst_n     = 1'b0;
      timer_irq = 1'b0;
      ext_irq   = 1'b0;
      op(1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0);
      chk("rst_in_trap_epc_taken", {31'h0, bus_if.epc_taken}, 32'h0);
      chk("rst_in_trap_epc", bus_if.epc, 32'h0);
      rst_n = 1'b1;
      read_reset_values("rst2");

      repeat (3) @(posedge clk);
      #1;
      chk("reads_outstanding", 32'(rd_q.size()), 32'h0);
      chk("redirects_outstanding", 32'(epc_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
